// File: rtl/bpuf_response_reader.sv
// Evaluation controller for a bistable-ring PUF array: excite, settle, sample, majority vote.
// Optional per-cell disagreement mask enabled with `define BPUF_STABILITY_EN.
module bpuf_response_reader #(
    parameter int N_CELLS       = 8,
    parameter int EXCITE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int N_EVAL        = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CELLS-1:0] puf_q,
    output logic               excite,
    output logic               busy,
    output logic               valid,
    output logic [N_CELLS-1:0] response,
    output logic [N_CELLS-1:0] unstable
);

    localparam int TMAX = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int VW   = $clog2(N_EVAL + 1);

    localparam logic [TW-1:0] E_LAST = TW'(EXCITE_CYCLES - 1);
    localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] HALF   = VW'(N_EVAL / 2);
    localparam logic [VW-1:0] LAST   = VW'(N_EVAL - 1);

    if ((N_EVAL < 1) || (N_EVAL % 2 == 0)) begin : g_bad_neval
        $error("bpuf_response_reader: N_EVAL must be odd and >= 1");
    end
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("bpuf_response_reader: SETTLE_CYCLES must be >= 2");
    end
    if (EXCITE_CYCLES < 1) begin : g_bad_excite
        $error("bpuf_response_reader: EXCITE_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        EXCITE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [TW-1:0]      timer;
    logic [VW-1:0]      eval_cnt;
    logic [VW-1:0]      vote    [N_CELLS];
    logic [VW-1:0]      vote_nx [N_CELLS];
    logic [N_CELLS-1:0] majority;
    logic [N_CELLS-1:0] sync1, sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync_q <= '0;
        end else begin
            sync1  <= puf_q;
            sync_q <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = EXCITE;
            EXCITE:  if (timer == E_LAST) state_nx = SETTLE;
            SETTLE:  if (timer == S_LAST) state_nx = SAMPLE;
            SAMPLE:  state_nx = (eval_cnt == LAST) ? DONE : EXCITE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            vote_nx[i]  = vote[i] + VW'(sync_q[i]);
            majority[i] = (vote_nx[i] > HALF);
        end
    end

    // Outputs are registered from the next state so they line up with the state itself;
    // the response is latched on the final SAMPLE edge so it is already valid during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            eval_cnt <= '0;
            excite   <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            response <= '0;
            for (int unsigned i = 0; i < N_CELLS; i++) vote[i] <= '0;
        end else begin
            excite <= (state_nx == EXCITE);
            busy   <= (state_nx != IDLE);
            valid  <= (state_nx == DONE);
            if ((state_nx == state) && ((state == EXCITE) || (state == SETTLE)))
                timer <= timer + TW'(1);
            else
                timer <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        eval_cnt <= '0;
                        for (int unsigned i = 0; i < N_CELLS; i++) vote[i] <= '0;
                    end
                end
                SAMPLE: begin
                    eval_cnt <= eval_cnt + VW'(1);
                    for (int unsigned i = 0; i < N_CELLS; i++) vote[i] <= vote_nx[i];
                    if (eval_cnt == LAST) response <= majority;
                end
                default: ;
            endcase
        end
    end

`ifdef BPUF_STABILITY_EN
    logic [N_CELLS-1:0] first_q, differ, differ_nx;

    assign differ_nx = (eval_cnt == '0) ? '0 : (differ | (sync_q ^ first_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q  <= '0;
            differ   <= '0;
            unstable <= '0;
        end else if ((state == IDLE) && start) begin
            differ <= '0;
        end else if (state == SAMPLE) begin
            if (eval_cnt == '0) first_q <= sync_q;
            differ <= differ_nx;
            if (eval_cnt == LAST) unstable <= differ_nx;
        end
    end
`else
    assign unstable = '0;
`endif

endmodule

// File: tb/tb_bpuf_response_reader.sv
// Directed, table-driven bench for bpuf_response_reader (defaults plus an N_EVAL=1 instance).
module tb_bpuf_response_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] puf_q = 8'h00;
    logic       excite, busy, valid;
    logic [7:0] response, unstable;
    logic       excite2, busy2, valid2;
    logic [7:0] response2, unstable2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bpuf_response_reader #(.N_CELLS(8), .EXCITE_CYCLES(4), .SETTLE_CYCLES(16), .N_EVAL(5)) dut (
        .clk(clk), .rst(rst), .start(start), .puf_q(puf_q),
        .excite(excite), .busy(busy), .valid(valid),
        .response(response), .unstable(unstable)
    );

    bpuf_response_reader #(.N_CELLS(8), .EXCITE_CYCLES(4), .SETTLE_CYCLES(16), .N_EVAL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .puf_q(puf_q),
        .excite(excite2), .busy(busy2), .valid(valid2),
        .response(response2), .unstable(unstable2)
    );

    typedef struct {
        logic [39:0] samples;   // byte e = steady puf_q during evaluation e
        bit          tog;
        logic [7:0]  exp_resp;
        logic [7:0]  exp_unst;  // expectation with the stability mask enabled
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] unst_exp(input logic [7:0] u);
`ifdef BPUF_STABILITY_EN
        return u;
`else
        return 8'h00;
`endif
    endfunction

    task automatic run_vec(input logic [39:0] s, input bit tog, input bit hold,
                           input logic [7:0] er, input logic [7:0] eu, input string tag);
        int vcyc = 0, nval = 0, pulses = 0, elen = 0, ev = 0;
        bit prev = 1'b0, wbad = 1'b0, sbad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) start = 1'b0;
            if (excite) begin
                if (!prev) begin
                    if (c <= 106) begin
                        if (c != 1 + 21 * pulses) sbad = 1'b1;
                        pulses++;
                    end
                    elen = 0;
                end
                elen++;
                if (tog) puf_q = 8'($urandom);
            end else if (prev) begin
                if (elen != 4) wbad = 1'b1;
                if (ev < 5) puf_q = s[8*ev +: 8];
                ev++;
            end
            prev = excite;
            if (valid) begin
                nval++;
                if (vcyc == 0) begin
                    vcyc = c;
                    check({tag, " response"}, int'(response), int'(er));
                    check({tag, " unstable"}, int'(unstable), int'(unst_exp(eu)));
                end
            end
            if (c == 107) check({tag, " busy after done"}, int'(busy), 0);
            if (c == 108) check({tag, " excite restart"}, int'(excite), int'(hold));
        end
        start = 1'b0;
        check({tag, " valid cycle"}, vcyc, 106);
        check({tag, " valid count"}, nval, 1);
        check({tag, " pulse count"}, pulses, 5);
        check({tag, " pulse spacing"}, int'(sbad), 0);
        check({tag, " pulse width"}, int'(wbad), 0);
        check({tag, " response held"}, int'(response), int'(er));
    endtask

    task automatic settle_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int vcyc, nval;
        bit sawv;
        vecs[0] = '{40'hA5A5A5A5A5, 1'b0, 8'hA5, 8'h00};
        vecs[1] = '{40'hF1F2F0F3F1, 1'b0, 8'hF1, 8'h03};
        vecs[2] = '{40'h3C3C3C3C3C, 1'b1, 8'h3C, 8'h00};
        vecs[3] = '{40'hFF00FF00FF, 1'b0, 8'hFF, 8'hFF};
        vecs[4] = '{40'h000000FFFF, 1'b0, 8'h00, 8'hFF};
        vecs[5] = '{40'h0080808080, 1'b0, 8'h80, 8'h80};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset excite", int'(excite), 0);
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(valid), 0);
        check("reset response", int'(response), 0);
        check("reset unstable", int'(unstable), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_vec(vecs[i].samples, vecs[i].tog, 1'b0, vecs[i].exp_resp,
                    vecs[i].exp_unst, $sformatf("vec%0d", i));

        // start held high: single valid, restart right after DONE
        run_vec(vecs[0].samples, 1'b0, 1'b1, 8'hA5, 8'h00, "hold");
        settle_idle();
        @(negedge clk);
        check("idle before abort run", int'(busy), 0);

        // reset during SETTLE of evaluation 3 (cycles 47..62 of the run)
        sawv = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (valid) sawv = 1'b1;
        end
        check("abort busy before rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort excite", int'(excite), 0);
        check("abort busy", int'(busy), 0);
        check("abort response", int'(response), 0);
        repeat (3) begin
            @(negedge clk);
            if (valid) sawv = 1'b1;
        end
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (valid) sawv = 1'b1;
        end
        check("abort no valid", int'(sawv), 0);
        run_vec(vecs[1].samples, 1'b0, 1'b0, 8'hF1, 8'h03, "after abort");

        // N_EVAL = 1 instance
        puf_q = 8'h6B;
        vcyc = 0;
        nval = 0;
        @(negedge clk);
        start2 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
            if (valid2) begin
                nval++;
                if (vcyc == 0) vcyc = c;
            end
        end
        check("neval1 valid cycle", vcyc, 22);
        check("neval1 valid count", nval, 1);
        check("neval1 response", int'(response2), 'h6B);
        check("neval1 unstable", int'(unstable2), 0);
        check("neval1 idle", int'(busy2), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
